// File: rtl/core_rf_gpr_mp.sv
// core_rf_gpr_mp: multi-port GPR file with two write-back ports,
// same-cycle write-to-read bypass, a pending-load scoreboard and a
// post-reset init sequence that zeroes every register.

// One read port: selects regmem/pend by address, applies the wb bypass,
// and forces zero output for out-of-range addresses or while initialising.
module core_rf_gpr_mp_rdport #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                           i_busy,
  input  logic [ADDR_W-1:0]              i_addr,
  input  logic [NREGS-1:0][DATA_W-1:0]   i_mem,
  input  logic [NREGS-1:0]               i_pend,
  input  logic                           i_wb0_en,
  input  logic [ADDR_W-1:0]              i_wb0_addr,
  input  logic [DATA_W-1:0]              i_wb0_data,
  input  logic                           i_wb1_en,
  input  logic [ADDR_W-1:0]              i_wb1_addr,
  input  logic [DATA_W-1:0]              i_wb1_data,
  output logic [DATA_W-1:0]              o_data,
  output logic                           o_pending
);
  logic              w_inrange;
  logic [DATA_W-1:0] w_mem;
  logic              w_pend;
  logic              w_hit0;
  logic              w_hit1;

  // Address decode by compare, so addresses >= NREGS simply match nothing.
  always_comb begin
    w_inrange = 1'b0;
    w_mem     = '0;
    w_pend    = 1'b0;
    for (int j = 0; j < NREGS; j++) begin
      if (i_addr == ADDR_W'(j)) begin
        w_inrange = 1'b1;
        w_mem     = i_mem[j];
        w_pend    = i_pend[j];
      end
    end
  end

  assign w_hit1 = i_wb1_en && (i_wb1_addr == i_addr);
  assign w_hit0 = i_wb0_en && (i_wb0_addr == i_addr);

  // Bypass priority wb1 > wb0 > regmem; pending is masked by a returning load.
  always_comb begin
    o_data    = '0;
    o_pending = 1'b0;
    if (!i_busy && w_inrange) begin
      if (w_hit1)      o_data = i_wb1_data;
      else if (w_hit0) o_data = i_wb0_data;
      else             o_data = w_mem;
      o_pending = w_pend & ~w_hit1;
    end
  end
endmodule

module core_rf_gpr_mp #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int NRD    = 3,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NRD*ADDR_W-1:0]    i_rd_addr,
  output logic [NRD*DATA_W-1:0]    o_rd_data,
  output logic [NRD-1:0]           o_rd_pending,
  input  logic                     i_wb0_en,
  input  logic [ADDR_W-1:0]        i_wb0_addr,
  input  logic [DATA_W-1:0]        i_wb0_data,
  input  logic                     i_wb1_en,
  input  logic [ADDR_W-1:0]        i_wb1_addr,
  input  logic [DATA_W-1:0]        i_wb1_data,
  input  logic                     i_sb_set,
  input  logic [ADDR_W-1:0]        i_sb_addr,
  output logic                     o_init_busy
);
  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

  state_t                       r_state;
  logic [ADDR_W-1:0]            r_cnt;
  logic [NREGS-1:0][DATA_W-1:0] r_mem;
  logic [NREGS-1:0]             r_pend;
  logic                         w_busy;

  // Busy also covers the cycle rst is held, so nothing leaks out or lands then.
  assign w_busy      = (r_state == S_INIT) | i_rst;
  assign o_init_busy = w_busy;

  // INIT/RUN sequencer, register writes and scoreboard update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_pend  <= '0;
    end else if (r_state == S_INIT) begin
      for (int j = 0; j < NREGS; j++)
        if (r_cnt == ADDR_W'(j)) r_mem[j] <= '0;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_state <= S_RUN;
    end else begin
      for (int j = 0; j < NREGS; j++) begin
        // wb1 (load) wins a same-address collision with wb0.
        if (i_wb1_en && i_wb1_addr == ADDR_W'(j))      r_mem[j] <= i_wb1_data;
        else if (i_wb0_en && i_wb0_addr == ADDR_W'(j)) r_mem[j] <= i_wb0_data;
        // A new load issued behind the returning one keeps the bit set.
        if (i_sb_set && i_sb_addr == ADDR_W'(j))       r_pend[j] <= 1'b1;
        else if (i_wb1_en && i_wb1_addr == ADDR_W'(j)) r_pend[j] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    core_rf_gpr_mp_rdport #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .i_busy     (w_busy),
      .i_addr     (i_rd_addr[k*ADDR_W +: ADDR_W]),
      .i_mem      (r_mem),
      .i_pend     (r_pend),
      .i_wb0_en   (i_wb0_en),
      .i_wb0_addr (i_wb0_addr),
      .i_wb0_data (i_wb0_data),
      .i_wb1_en   (i_wb1_en),
      .i_wb1_addr (i_wb1_addr),
      .i_wb1_data (i_wb1_data),
      .o_data     (o_rd_data[k*DATA_W +: DATA_W]),
      .o_pending  (o_rd_pending[k])
    );
  end
endmodule
